// File: rtl/terminal_controller.sv
// Character-stream front end for the 80x30 text terminal: cursor tracking, control codes, clear and scroll.
// Optional build macro TERMINAL_SCROLL_EN enables end-of-screen scroll; otherwise the cursor wraps to row 0.
module terminal_controller #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              charValid,
    input  logic [7:0]        charData,
    output logic              charReady,
    input  logic              clearRequest,
    output logic [ADDR_W-1:0] textAddress,
    input  logic [7:0]        textReadData,
    output logic              shouldWriteText,
    output logic [7:0]        textWriteData,
    output logic [6:0]        cursorX,
    output logic [4:0]        cursorY,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [7:0]        SPACE     = 8'h20;
`ifdef TERMINAL_SCROLL_EN
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        CLR_ALL
`ifdef TERMINAL_SCROLL_EN
        ,
        COPY_RD,
        COPY_WR,
        CLR_ROW
`endif
    } state_t;

    state_t            state, stateNext;
    logic [6:0]        cursorXNext;
    logic [4:0]        cursorYNext;
    logic [ADDR_W-1:0] addressNext, cellIndex, cellIndexNext;
    logic              writeNext, rowAdvance;
    logic [7:0]        writeDataNext, charByte, charByteNext;

`ifndef TERMINAL_SCROLL_EN
    logic unusedReadData;
    assign unusedReadData = ^textReadData;
`endif

    function automatic logic [ADDR_W-1:0] cellAddr(input logic [6:0] x, input logic [4:0] y);
        return ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);
    endfunction

    function automatic logic isPrintable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    assign charReady = (state == IDLE) && !clearRequest;
    assign busy      = (state != IDLE);

    // Address/strobe/data registers are loaded with the values for the state being entered,
    // so a write is presented during the cycle of the state that owns it.
    always_comb begin
        stateNext     = state;
        cursorXNext   = cursorX;
        cursorYNext   = cursorY;
        addressNext   = cellAddr(cursorX, cursorY);
        writeNext     = 1'b0;
        writeDataNext = textWriteData;
        charByteNext  = charByte;
        cellIndexNext = cellIndex;
        rowAdvance    = 1'b0;
        case (state)
            IDLE: begin
                if (clearRequest) begin
                    stateNext     = CLR_ALL;
                    cursorXNext   = '0;
                    cursorYNext   = '0;
                    addressNext   = '0;
                    cellIndexNext = '0;
                    writeNext     = 1'b1;
                    writeDataNext = SPACE;
                end else if (charValid) begin
                    stateNext    = PUT;
                    charByteNext = charData;
                    if (isPrintable(charData)) begin
                        writeNext     = 1'b1;
                        writeDataNext = charData;
                    end else if (charData == 8'h08 && cursorX != '0) begin
                        addressNext   = cellAddr(cursorX - 7'd1, cursorY);
                        writeNext     = 1'b1;
                        writeDataNext = SPACE;
                    end
                end
            end
            PUT: begin
                stateNext = IDLE;
                if (isPrintable(charByte)) begin
                    if (cursorX == 7'(COLS - 1)) begin
                        cursorXNext = '0;
                        rowAdvance  = 1'b1;
                    end else begin
                        cursorXNext = cursorX + 7'd1;
                    end
                end else if (charByte == 8'h0D) begin
                    cursorXNext = '0;
                end else if (charByte == 8'h0A) begin
                    cursorXNext = '0;
                    rowAdvance  = 1'b1;
                end else if (charByte == 8'h08 && cursorX != '0) begin
                    cursorXNext = cursorX - 7'd1;
                end
                if (rowAdvance && cursorY == 5'(ROWS - 1)) begin
`ifdef TERMINAL_SCROLL_EN
                    cursorYNext = cursorY;
`else
                    cursorYNext = '0;
`endif
                end else if (rowAdvance) begin
                    cursorYNext = cursorY + 5'd1;
                end
                addressNext = cellAddr(cursorXNext, cursorYNext);
`ifdef TERMINAL_SCROLL_EN
                if (rowAdvance && cursorY == 5'(ROWS - 1)) begin
                    stateNext     = COPY_RD;
                    cellIndexNext = ADDR_W'(COLS);
                    addressNext   = ADDR_W'(COLS);
                end
`endif
            end
            CLR_ALL: begin
                if (cellIndex == LAST_CELL) begin
                    stateNext = IDLE;
                end else begin
                    cellIndexNext = cellIndex + 1'b1;
                    addressNext   = cellIndex + 1'b1;
                    writeNext     = 1'b1;
                    writeDataNext = SPACE;
                end
            end
`ifdef TERMINAL_SCROLL_EN
            COPY_RD: begin
                stateNext     = COPY_WR;
                addressNext   = cellIndex - ADDR_W'(COLS);
                writeNext     = 1'b1;
                writeDataNext = textReadData;
            end
            COPY_WR: begin
                if (cellIndex == LAST_CELL) begin
                    stateNext     = CLR_ROW;
                    cellIndexNext = LAST_ROW_BASE;
                    addressNext   = LAST_ROW_BASE;
                    writeNext     = 1'b1;
                    writeDataNext = SPACE;
                end else begin
                    stateNext     = COPY_RD;
                    cellIndexNext = cellIndex + 1'b1;
                    addressNext   = cellIndex + 1'b1;
                end
            end
            CLR_ROW: begin
                if (cellIndex == LAST_CELL) begin
                    stateNext = IDLE;
                end else begin
                    cellIndexNext = cellIndex + 1'b1;
                    addressNext   = cellIndex + 1'b1;
                    writeNext     = 1'b1;
                    writeDataNext = SPACE;
                end
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cursorX         <= '0;
            cursorY         <= '0;
            textAddress     <= '0;
            shouldWriteText <= 1'b0;
            textWriteData   <= '0;
            charByte        <= '0;
            cellIndex       <= '0;
        end else begin
            state           <= stateNext;
            cursorX         <= cursorXNext;
            cursorY         <= cursorYNext;
            textAddress     <= addressNext;
            shouldWriteText <= writeNext;
            textWriteData   <= writeDataNext;
            charByte        <= charByteNext;
            cellIndex       <= cellIndexNext;
        end
    end

endmodule

// File: tb/tb_terminal_controller.sv
// Directed self-checking bench for terminal_controller with a behavioural text RAM.
// Scroll expectations follow TERMINAL_SCROLL_EN when it is defined for the build.
module tb_terminal_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        charValid = 1'b0;
    logic [7:0]  charData = '0;
    logic        charReady;
    logic        clearRequest = 1'b0;
    logic [11:0] textAddress;
    logic [7:0]  textReadData;
    logic        shouldWriteText;
    logic [7:0]  textWriteData;
    logic [6:0]  cursorX;
    logic [4:0]  cursorY;
    logic        busy;

    logic [7:0]  ram [0:4095];
    int          checks = 0;
    int          errors = 0;
    int          writeCount = 0;
    int          writeBase, lastBusy, bad, expAddr, n;
    logic        lastWr, lastReady;
    logic [11:0] lastAddr;
    logic [7:0]  lastData;

    terminal_controller #(.COLS(80), .ROWS(30), .ADDR_W(12)) dut (
        .clock(clock), .reset(reset), .charValid(charValid), .charData(charData),
        .charReady(charReady), .clearRequest(clearRequest), .textAddress(textAddress),
        .textReadData(textReadData), .shouldWriteText(shouldWriteText),
        .textWriteData(textWriteData), .cursorX(cursorX), .cursorY(cursorY), .busy(busy)
    );

    always #5 clock = ~clock;

    assign textReadData = ram[textAddress];

    always @(posedge clock) begin
        if (shouldWriteText === 1'b1) begin
            ram[textAddress] = textWriteData;
            writeCount = writeCount + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the controller is idle again.
    task automatic sendByte(input logic [7:0] b);
        int k;
        k = 0;
        while (!charReady && k < 100) begin
            @(negedge clock);
            k++;
        end
        charData  = b;
        charValid = 1'b1;
        @(negedge clock);
        charValid = 1'b0;
        lastWr    = shouldWriteText;
        lastAddr  = textAddress;
        lastData  = textWriteData;
        lastReady = charReady;
        k = 0;
        while (busy && k < 10000) begin
            @(negedge clock);
            k++;
        end
        lastBusy = k;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        repeat (2) @(negedge clock);
        check("rst_x", 32'(cursorX), 0);
        check("rst_y", 32'(cursorY), 0);
        check("rst_we", 32'(shouldWriteText), 0);
        check("rst_wd", 32'(textWriteData), 0);
        check("rst_addr", 32'(textAddress), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_idle", 32'(charReady), 1);

        sendByte(8'h41);
        check("A_we", 32'(lastWr), 1);
        check("A_addr", 32'(lastAddr), 0);
        check("A_data", 32'(lastData), 32'h41);
        check("A_ready_low", 32'(lastReady), 0);
        check("A_ready_back", 32'(charReady), 1);
        check("A_busy_cycles", lastBusy, 1);
        check("A_x", 32'(cursorX), 1);
        check("A_y", 32'(cursorY), 0);
        check("A_ram", 32'(ram[0]), 32'h41);

        sendByte(8'h0A);
        sendByte(8'h0A);
        for (int i = 0; i < 5; i++) sendByte(8'h44);
        check("pre_bs_x", 32'(cursorX), 5);
        check("pre_bs_y", 32'(cursorY), 2);
        sendByte(8'h08);
        check("bs_we", 32'(lastWr), 1);
        check("bs_addr", 32'(lastAddr), 164);
        check("bs_data", 32'(lastData), 32'h20);
        check("bs_x", 32'(cursorX), 4);
        check("bs_y", 32'(cursorY), 2);
        sendByte(8'h0D);
        writeBase = writeCount;
        sendByte(8'h08);
        check("bs0_we", 32'(lastWr), 0);
        check("bs0_x", 32'(cursorX), 0);
        check("bs0_y", 32'(cursorY), 2);
        sendByte(8'h01);
        check("ign_we", 32'(lastWr), 0);
        check("ign_writes", writeCount - writeBase, 0);
        check("ign_x", 32'(cursorX), 0);

        // clear wins over a same-cycle character
        writeBase    = writeCount;
        clearRequest = 1'b1;
        charValid    = 1'b1;
        charData     = 8'h5A;
        #1 check("clr_ready", 32'(charReady), 0);
        @(negedge clock);
        clearRequest = 1'b0;
        charValid    = 1'b0;
        bad = 0;
        expAddr = 0;
        n = 0;
        while (busy && n < 3000) begin
            if (shouldWriteText) begin
                if (textAddress !== 12'(expAddr) || textWriteData !== 8'h20) bad++;
                expAddr++;
            end
            @(negedge clock);
            n++;
        end
        check("clr_cycles", n, 2400);
        check("clr_seq_bad", bad, 0);
        check("clr_writes", writeCount - writeBase, 2400);
        check("clr_x", 32'(cursorX), 0);
        check("clr_y", 32'(cursorY), 0);
        check("clr_ram0", 32'(ram[0]), 32'h20);

        for (int i = 0; i < 79; i++) sendByte(8'h42);
        check("B79_x", 32'(cursorX), 79);
        sendByte(8'h43);
        check("C_addr", 32'(lastAddr), 79);
        check("C_data", 32'(lastData), 32'h43);
        check("C_x", 32'(cursorX), 0);
        check("C_y", 32'(cursorY), 1);
        writeBase = writeCount;
        sendByte(8'h0D);
        sendByte(8'h0A);
        check("crlf_x", 32'(cursorX), 0);
        check("crlf_y", 32'(cursorY), 2);
        check("crlf_writes", writeCount - writeBase, 0);

        for (int i = 0; i < 27; i++) sendByte(8'h0A);
        check("bottom_y", 32'(cursorY), 29);
        for (int i = 80; i < 160; i++) ram[i] = 8'h78;
        for (int i = 2320; i < 2400; i++) ram[i] = 8'h71;
        writeBase = writeCount;
        sendByte(8'h0A);
`ifdef TERMINAL_SCROLL_EN
        check("scr_busy_cycles", lastBusy, 1 + 4720);
        check("scr_writes", writeCount - writeBase, 2400);
        check("scr_x", 32'(cursorX), 0);
        check("scr_y", 32'(cursorY), 29);
        bad = 0;
        for (int i = 0; i < 80; i++) if (ram[i] !== 8'h78) bad++;
        check("scr_row0_bad", bad, 0);
        bad = 0;
        for (int i = 2320; i < 2400; i++) if (ram[i] !== 8'h20) bad++;
        check("scr_row29_bad", bad, 0);

        charData  = 8'h0A;
        charValid = 1'b1;
        @(negedge clock);
        charValid = 1'b0;
`else
        check("wrap_busy_cycles", lastBusy, 1);
        check("wrap_writes", writeCount - writeBase, 0);
        check("wrap_x", 32'(cursorX), 0);
        check("wrap_y", 32'(cursorY), 0);
        check("wrap_row0", 32'(ram[0]), 32'h42);

        sendByte(8'h0A);
        clearRequest = 1'b1;
        @(negedge clock);
        clearRequest = 1'b0;
`endif
        repeat (100) @(negedge clock);
        check("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("mr_we", 32'(shouldWriteText), 0);
        check("mr_addr", 32'(textAddress), 0);
        check("mr_wd", 32'(textWriteData), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_x", 32'(cursorX), 0);
        check("mr_y", 32'(cursorY), 0);
        @(negedge clock);
        reset = 1'b0;
        #1 check("mr_ready", 32'(charReady), 1);
        @(negedge clock);
        check("mr_idle_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
